// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- 32-bit registered arithmetic/logic unit for the execute stage.
//
// Each cycle with En=1 the unit samples A, B and Op. It registers the result
// and its flags, so they are visible from the following clock edge. It makes
// no stall decisions.
//
// Handshake: En is a one-cycle "accept" strobe with no back-pressure, because
// the unit is always ready. Valid goes high for exactly the cycle after each
// accepted En. With En=0 the result and flags hold, and Valid drops.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset (wins over En)
//   En     sample A/B/Op this cycle
//   A      operand A; also the sole operand for NOT, shifts and rotates
//   B      operand B (ignored for NOT, shifts and rotates)
//   Op     4-bit opcode
//   Out    registered result
//   Zero   registered, 1 when Out == 0
//   Carry  registered unsigned carry (ADD) or no-borrow (SUB), else 0
//   Ovf    registered two's-complement overflow (ADD/SUB), else 0
//   Valid  registered, 1 the cycle after an accepted En
// -----------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  Op,
  output logic [31:0] Out,
  output logic        Zero,
  output logic        Carry,
  output logic        Ovf,
  output logic        Valid
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1100;
  localparam logic [3:0] OP_ROR = 4'b1101;

  // ADD and SUB share one 33-bit adder.
  // For SUB the adder computes A + ~B + 1, so bit 32 is the no-borrow flag.
  logic        is_sub;
  logic [31:0] add_b;
  logic [32:0] sum;

  assign is_sub = (Op == OP_SUB);
  assign add_b  = is_sub ? ~B : B;
  assign sum    = {1'b0, A} + {1'b0, add_b} + {32'd0, is_sub};

  logic [31:0] res;
  logic        res_c;
  logic        res_v;

  always_comb begin
    res   = 32'd0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (Op)
      OP_ADD: begin
        res   = sum[31:0];
        res_c = sum[32];
        // Operands agree in sign, but the result does not.
        res_v = (A[31] == B[31]) && (sum[31] != A[31]);
      end
      OP_SUB: begin
        res   = sum[31:0];
        res_c = sum[32];
        // Operands differ in sign, and the result left A's sign.
        res_v = (A[31] != B[31]) && (sum[31] != A[31]);
      end
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_NOT:  res = ~A;
      OP_SRA:  res = {A[31], A[31:1]};
      OP_SLL:  res = {A[30:0], 1'b0};
      OP_SRL:  res = {1'b0, A[31:1]};
      OP_ROL:  res = {A[30:0], A[31]};
      OP_ROR:  res = {A[0], A[31:1]};
      default: res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Out   <= 32'd0;
      Zero  <= 1'b1;
      Carry <= 1'b0;
      Ovf   <= 1'b0;
      Valid <= 1'b0;
    end else begin
      Valid <= En;
      if (En) begin
        Out   <= res;
        Zero  <= (res == 32'd0);
        Carry <= res_c;
        Ovf   <= res_v;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
// Uses directed steps and then randomized operations. A behavioural reference
// model computes each expected value, and an immediate assertion checks it.
// -----------------------------------------------------------------------------
module tb_alu;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] out;
  logic        zero;
  logic        carry;
  logic        ovf;
  logic        valid;

  always #5 clk = ~clk;

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .En    (en),
    .A     (a),
    .B     (b),
    .Op    (op),
    .Out   (out),
    .Zero  (zero),
    .Carry (carry),
    .Ovf   (ovf),
    .Valid (valid)
  );

  // ---------------- scoreboard ----------------
  // Packed as {valid, ovf, carry, zero, out}.
  logic [35:0] exp_q[$];
  int          tests  = 0;
  int          failed = 0;

  // Architectural state the model keeps between operations.
  logic [31:0] m_out   = 32'd0;
  logic        m_carry = 1'b0;
  logic        m_ovf   = 1'b0;
  logic        m_valid = 1'b0;

  // Reference: plain arithmetic on the operands, with overflow judged by
  // doing the signed operation in 64 bits and range-checking it.
  task automatic ref_op(input logic [31:0] ra, input logic [31:0] rb,
                        input logic [3:0] rop, output logic [31:0] r,
                        output logic c, output logic v);
    longint      s;
    logic [32:0] wide;
    logic signed [31:0] sa;
    r = 32'd0;
    c = 1'b0;
    v = 1'b0;
    sa = ra;
    case (rop)
      4'd0: begin
        wide = {1'b0, ra} + {1'b0, rb};
        r = wide[31:0];
        c = wide[32];
        s = longint'($signed(ra)) + longint'($signed(rb));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = ra - rb;
        c = (ra >= rb);
        s = longint'($signed(ra)) - longint'($signed(rb));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  r = ra & rb;
      4'd3:  r = ra | rb;
      4'd4:  r = ~ra;
      4'd8:  r = sa >>> 1;
      4'd9:  r = ra << 1;
      4'd10: r = ra >> 1;
      4'd12: r = (ra << 1) | (ra >> 31);
      4'd13: r = (ra >> 1) | (ra << 31);
      default: r = 32'd0;
    endcase
  endtask

  // ---------------- driver ----------------
  // Drive one cycle, advance the model, and push the expected outputs.
  task automatic step(input logic r_in, input logic e_in, input logic [31:0] a_in,
                      input logic [31:0] b_in, input logic [3:0] op_in);
    logic [31:0] r;
    logic        c;
    logic        v;
    rst = r_in;
    en  = e_in;
    a   = a_in;
    b   = b_in;
    op  = op_in;
    @(posedge clk);
    #1;
    if (r_in) begin
      m_out = 32'd0; m_carry = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = e_in;
      if (e_in) begin
        ref_op(a_in, b_in, op_in, r, c, v);
        m_out = r; m_carry = c; m_ovf = v;
      end
    end
    exp_q.push_back({m_valid, m_ovf, m_carry, (m_out == 32'd0), m_out});
  endtask

  task automatic check(input string tag);
    logic [35:0] e;
    logic [35:0] got;
    e   = exp_q.pop_front();
    got = {valid, ovf, carry, zero, out};
    tests++;
    assert (got === e) else begin
      failed++;
      $error("FAIL %s: got valid/ovf/carry/zero/out=%b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
             tag, got[35], got[34], got[33], got[32], got[31:0],
             e[35], e[34], e[33], e[32], e[31:0]);
    end
  endtask

  // Direct check of a constant spec value, independent of the model.
  task automatic check_out(input string tag, input logic [31:0] want);
    tests++;
    assert (out === want) else begin
      failed++;
      $error("FAIL %s: got out=%h want %h", tag, out, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    logic [31:0] corners[6];
    corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
    corners[4] = 32'h0000_0001; corners[5] = 32'h8000_0001;

    rst = 1'b1; en = 1'b1; a = 32'd5; b = 32'd3; op = 4'b0000;

    // Reset with En active: reset must win.
    step(1, 1, 32'd5, 32'd3, 4'd0); check("reset_c1");
    step(1, 1, 32'd5, 32'd3, 4'd0); check("reset_c2");
    check_out("reset_out", 32'd0);

    // Basic ops, back to back.
    step(0, 1, 32'd2, 32'd1, 4'd0); check("add_2_1");  check_out("add_2_1_val", 32'd3);
    step(0, 1, 32'd2, 32'd1, 4'd1); check("sub_2_1");
    step(0, 1, 32'd2, 32'd1, 4'd2); check("and_2_1");
    step(0, 1, 32'd2, 32'd1, 4'd3); check("or_2_1");
    step(0, 1, 32'd2, 32'd1, 4'd4); check("not_2");    check_out("not_2_val", 32'hFFFF_FFFD);

    // Logic.
    step(0, 1, 32'h0F, 32'h0A, 4'd2); check("and_f_a");
    step(0, 1, 32'd11, 32'd20, 4'd2); check("and_11_20");

    // Flag corners.
    step(0, 1, 32'h7FFF_FFFF, 32'd1, 4'd0); check("add_ovf");
    step(0, 1, 32'hFFFF_FFFF, 32'd1, 4'd0); check("add_carry");
    step(0, 1, 32'd1, 32'd2, 4'd1);         check("sub_borrow");
    check_out("sub_borrow_val", 32'hFFFF_FFFF);
    step(0, 1, 32'h8000_0000, 32'd1, 4'd1); check("sub_ovf");

    // Shifts and rotates.
    step(0, 1, 32'h8000_0001, 32'd7, 4'd8);  check("sra");
    check_out("sra_val", 32'hC000_0000);
    step(0, 1, 32'h8000_0001, 32'd7, 4'd10); check("srl");
    step(0, 1, 32'h8000_0001, 32'd7, 4'd9);  check("sll");
    step(0, 1, 32'h8000_0001, 32'd7, 4'd12); check("rol");
    check_out("rol_val", 32'h0000_0003);
    step(0, 1, 32'h8000_0001, 32'd7, 4'd13); check("ror");
    step(0, 1, 32'h8000_0001, 32'd7, 4'd7);  check("undef_7");

    // Hold: results stay while En=0, even as inputs change.
    step(0, 1, 32'd2, 32'd1, 4'd0); check("hold_add");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'd9, $urandom, 4'($urandom_range(0, 15)));
      check("hold_idle");
    end
    check_out("hold_val", 32'd3);

    // Randomized operations with a mix of corner operands, idle cycles
    // and occasional mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rop = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), ra, rb, rop);
      check("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
